// File: rtl/counter_prog_multi.sv
// Multi-channel programmable tick generator: NCH independent counters with runtime-loadable
// divisors, each emitting a registered one-cycle tick every d enabled clocks (periodic or one-shot).
module counter_prog_multi #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned NCH         = 4,
    parameter int unsigned DEFAULT_DIV = 25000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   wr_en,
    input  logic [$clog2(NCH)-1:0] wr_ch,
    input  logic [WIDTH-1:0]       wr_div,
    input  logic                   wr_mode,
    input  logic [NCH-1:0]         start,
    input  logic [NCH-1:0]         stop,
    output logic [NCH-1:0]         tick,
    output logic [NCH-1:0]         active,
    output logic [NCH*WIDTH-1:0]   count
);

    localparam int unsigned ChW = $clog2(NCH);
    localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] div_q, div_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] eff_div;
        logic             mode_q, mode_d;
        logic             act_q, act_d;
        logic             tick_q, tick_d;
        logic             wr_hit;
        logic             at_end;

        // Out-of-range channel numbers never match, so such writes are dropped.
        assign wr_hit  = wr_en && (wr_ch == ChW'(i));
        assign eff_div = (div_q == '0) ? WIDTH'(1) : div_q;
        assign at_end  = (cnt_q == eff_div - WIDTH'(1));

        always_comb begin
            div_d  = div_q;
            mode_d = mode_q;
            cnt_d  = cnt_q;
            act_d  = act_q;
            tick_d = 1'b0;
            if (wr_hit) begin
                div_d  = wr_div;
                mode_d = wr_mode;
                cnt_d  = '0;
                // A write leaves active alone, but a coincident stop/start still applies.
                if (stop[i]) begin
                    act_d = 1'b0;
                end else if (start[i]) begin
                    act_d = 1'b1;
                end
            end else if (stop[i]) begin
                act_d = 1'b0;
            end else if (start[i]) begin
                cnt_d = '0;
                act_d = 1'b1;
            end else if (en && act_q) begin
                if (at_end) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    if (mode_q) begin
                        act_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                div_q  <= DefDiv;
                mode_q <= 1'b0;
                cnt_q  <= '0;
                act_q  <= 1'b1;
                tick_q <= 1'b0;
            end else begin
                div_q  <= div_d;
                mode_q <= mode_d;
                cnt_q  <= cnt_d;
                act_q  <= act_d;
                tick_q <= tick_d;
            end
        end

        assign tick[i]                  = tick_q;
        assign active[i]                = act_q;
        assign count[i*WIDTH +: WIDTH] = cnt_q;
    end

endmodule

// File: tb/tb_counter_prog_multi.sv
// Self-checking bench for counter_prog_multi: per-cycle scoreboard against a behavioural model,
// a table for the free-running case and hand-written sequences for the multi-cycle corners.
module tb_counter_prog_multi;

    localparam int unsigned W   = 16;
    localparam int unsigned N   = 5;   // not a power of two so wr_ch = N is representable
    localparam int unsigned DEF = 5;

    logic           clk, reset, en, wr_en, wr_mode;
    logic [2:0]     wr_ch;
    logic [W-1:0]   wr_div;
    logic [N-1:0]   start, stop, tick, active;
    logic [N*W-1:0] count;

    counter_prog_multi #(.WIDTH(W), .NCH(N), .DEFAULT_DIV(DEF)) dut (
        .clk(clk), .reset(reset), .en(en), .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
        .wr_mode(wr_mode), .start(start), .stop(stop), .tick(tick), .active(active),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   tick;
        logic [N-1:0]   active;
        logic [N*W-1:0] count;
    } exp_t;

    typedef struct {
        logic         en;
        logic [N-1:0] exp_tick;
        logic [W-1:0] exp_cnt;
    } vec_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail = 0;

    logic [W-1:0] m_div[N];
    logic [W-1:0] m_cnt[N];
    logic         m_mode[N];
    logic         m_act[N];
    logic         m_tick[N];

    task automatic chk(input string name, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference behaviour for one clock edge, written straight from the priority list.
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                m_div[i] = W'(DEF); m_mode[i] = 1'b0; m_cnt[i] = '0;
                m_act[i] = 1'b1;    m_tick[i] = 1'b0;
            end else begin
                logic [W-1:0] d;
                d = (m_div[i] == 0) ? W'(1) : m_div[i];
                m_tick[i] = 1'b0;
                if (wr_en && (int'(wr_ch) == i)) begin
                    m_div[i] = wr_div; m_mode[i] = wr_mode; m_cnt[i] = '0;
                    if (stop[i]) m_act[i] = 1'b0;
                    else if (start[i]) m_act[i] = 1'b1;
                end else if (stop[i]) begin
                    m_act[i] = 1'b0;
                end else if (start[i]) begin
                    m_cnt[i] = '0; m_act[i] = 1'b1;
                end else if (en && m_act[i]) begin
                    if (m_cnt[i] == d - 1) begin
                        m_cnt[i] = '0; m_tick[i] = 1'b1;
                        if (m_mode[i]) m_act[i] = 1'b0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        for (int i = 0; i < N; i++) begin
            e.tick[i] = m_tick[i];
            e.active[i] = m_act[i];
            e.count[i*W +: W] = m_cnt[i];
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("sb_tick", N*W'(tick), N*W'(e.tick));
        chk("sb_active", N*W'(active), N*W'(e.active));
        chk("sb_count", count, e.count);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    vec_t tbl[20];

    initial begin
        for (int k = 0; k < 20; k++) begin
            tbl[k].en = 1'b1;
            tbl[k].exp_tick = ((k + 1) % 5 == 0) ? 5'h1f : 5'h00;
            tbl[k].exp_cnt = W'((k + 1) % 5);
        end

        reset = 1'b1; en = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_mode = 1'b0;
        start = '0; stop = '0;
        #1;
        steps(2);
        reset = 1'b0;
        chk("rst_tick", N*W'(tick), '0);
        chk("rst_active", N*W'(active), N*W'(5'h1f));
        chk("rst_count", count, '0);

        // Free-running at the default divisor
        for (int k = 0; k < 20; k++) begin
            en = tbl[k].en;
            step();
            chk("t1_tick", N*W'(tick), N*W'(tbl[k].exp_tick));
            chk("t1_cnt0", N*W'(count[0 +: W]), N*W'(tbl[k].exp_cnt));
            chk("t1_cnt4", N*W'(count[4*W +: W]), N*W'(tbl[k].exp_cnt));
        end

        // ch1 reprogrammed to 3 while ch0 keeps its phase
        wr_en = 1'b1; wr_ch = 3'd1; wr_div = 16'd3; wr_mode = 1'b0;
        step();
        wr_en = 1'b0;
        chk("t2_wr_cnt1", N*W'(count[W +: W]), '0);
        steps(3);
        chk("t2_tick_a", N*W'(tick), N*W'(5'b00010));
        chk("t2_cnt0", N*W'(count[0 +: W]), N*W'(4));
        step();
        chk("t2_tick_b", N*W'(tick), N*W'(5'b11101));

        // One-shot on ch2
        wr_en = 1'b1; wr_ch = 3'd2; wr_div = 16'd4; wr_mode = 1'b1; start = 5'b00100;
        step();
        wr_en = 1'b0; start = '0;
        steps(4);
        chk("t3_tick", N*W'(tick[2]), N*W'(1));
        chk("t3_act", N*W'(active[2]), '0);
        chk("t3_cnt", N*W'(count[2*W +: W]), '0);
        steps(4);
        chk("t3_idle_act", N*W'(active[2]), '0);
        chk("t3_idle_tick", N*W'(tick[2]), '0);
        start = 5'b00100;
        step();
        start = '0;
        steps(3);
        chk("t3_notyet", N*W'(tick[2]), '0);
        step();
        chk("t3_tick2", N*W'(tick[2]), N*W'(1));

        // en pause at count 2
        start = 5'b00001;
        step();
        start = '0;
        steps(2);
        en = 1'b0;
        steps(7);
        chk("t4_hold", N*W'(count[0 +: W]), N*W'(2));
        chk("t4_notick", N*W'(tick[0]), '0);
        en = 1'b1;
        steps(2);
        chk("t4_early", N*W'(tick[0]), '0);
        step();
        chk("t4_tick", N*W'(tick[0]), N*W'(1));

        // stop beats start, div 0, out-of-range write
        start = 5'b01000; stop = 5'b01000;
        step();
        start = '0; stop = '0;
        chk("t5_stopwin", N*W'(active[3]), '0);
        wr_en = 1'b1; wr_ch = 3'd3; wr_div = '0; wr_mode = 1'b0;
        step();
        wr_en = 1'b0;
        start = 5'b01000;
        step();
        start = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t5_div0", N*W'(tick[3]), N*W'(1));
        end
        wr_en = 1'b1; wr_ch = 3'd5; wr_div = 16'd7; wr_mode = 1'b1;
        step();
        wr_en = 1'b0;
        chk("t5_oor", N*W'(tick[3]), N*W'(1));

        // Reset mid-count
        start = 5'b00001;
        step();
        start = '0;
        steps(3);
        chk("t6_pre", N*W'(count[0 +: W]), N*W'(3));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_tick", N*W'(tick), '0);
        chk("t6_count", count, '0);
        chk("t6_active", N*W'(active), N*W'(5'h1f));
        steps(4);
        chk("t6_early", N*W'(tick), '0);
        step();
        chk("t6_defdiv", N*W'(tick), N*W'(5'h1f));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
